// File: rtl/cmp_edge_stamp.sv
// cmp_edge_stamp: multi-channel comparator edge timestamper (adc_clk domain).
// After an arm pulse, records per channel the sample index of the first
// comparator rising edge, counted from the first armed word, and returns the
// result through a valid/ready handshake. Ends by timeout if a channel never fires.
// Optional macro CMP_EDGE_POL_EN: adds per-channel edge_pol input
// (0 = rising, 1 = falling), sampled on the arm cycle.

// Per-channel edge finder: lowest rising-edge index within one word,
// using the previous word's last sample for the bit-0 comparison.
module cmp_edge_find #(
    parameter int WORD_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic [WORD_W-1:0] word,
    input  logic              prev,
    input  logic              pol,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] rise;
    logic              p;

    // Falling-edge mode is rising-edge detection on the inverted stream.
    assign w    = word ^ {WORD_W{pol}};
    assign p    = prev ^ pol;
    assign rise = w & ~{w[WORD_W-2:0], p};
    assign hit  = |rise;

    // Priority encode: scan downwards so the lowest set index wins.
    always_comb begin
        idx = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (rise[i]) idx = IDX_W'(i);
        end
    end
endmodule

module cmp_edge_stamp #(
    parameter int NUM_CH        = 2,
    parameter int WORD_W        = 8,
    parameter int CNT_W         = 10,
    parameter int TIMEOUT_WORDS = 1023,
    localparam int IDX_W        = $clog2(WORD_W),
    localparam int TS_W         = CNT_W + IDX_W
) (
    input  logic                     adc_clk,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic [NUM_CH*WORD_W-1:0] data_in,
`ifdef CMP_EDGE_POL_EN
    input  logic [NUM_CH-1:0]        edge_pol,
`endif
    input  logic                     arm,
    output logic                     busy,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [NUM_CH*TS_W-1:0]   ts_data,
    output logic [NUM_CH-1:0]        ts_hit,
    output logic                     timeout
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

    state_t state, state_nx;

    logic [NUM_CH-1:0][WORD_W-1:0] word_v;
    logic [NUM_CH-1:0][IDX_W-1:0]  edge_idx;
    logic [NUM_CH-1:0][TS_W-1:0]   ts_q;
    logic [NUM_CH-1:0]             prev_bit;
    logic [NUM_CH-1:0]             pol_q;
    logic [NUM_CH-1:0]             edge_hit;
    logic [NUM_CH-1:0]             new_hit;
    logic [NUM_CH-1:0]             hit_after;
    logic [CNT_W-1:0]              word_cnt;
    logic                          all_hit;
    logic                          last_word;
    logic                          arm_go;
    logic                          armed_ce;

    assign word_v    = data_in;
    assign ts_data   = ts_q;
    assign arm_go    = (state == S_IDLE) && arm;
    assign armed_ce  = (state == S_ARMED) && ce;
    assign new_hit   = edge_hit & ~ts_hit;
    assign hit_after = ts_hit | new_hit;
    assign all_hit   = &hit_after;
    assign last_word = (word_cnt == CNT_W'(TIMEOUT_WORDS - 1));
    assign busy      = (state != S_IDLE);
    assign ts_valid  = (state == S_DONE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cmp_edge_find #(.WORD_W(WORD_W), .IDX_W(IDX_W)) u_find (
            .word (word_v[g]),
            .prev (prev_bit[g]),
            .pol  (pol_q[g]),
            .hit  (edge_hit[g]),
            .idx  (edge_idx[g])
        );
    end

`ifdef CMP_EDGE_POL_EN
    // Edge polarity is latched at arm and held for the whole capture.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n)    pol_q <= '0;
        else if (arm_go) pol_q <= edge_pol;
    end
`else
    assign pol_q = '0;
`endif

    // Last sample of every valid word, kept in all states for boundary continuity.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_bit <= '0;
        end else if (ce) begin
            for (int c = 0; c < NUM_CH; c++) prev_bit[c] <= word_v[c][WORD_W-1];
        end
    end

    // State register.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state: arm only from IDLE, complete on all-hit or last counted word.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (arm) state_nx = S_ARMED;
            S_ARMED: if (ce && (all_hit || last_word)) state_nx = S_DONE;
            S_DONE:  if (ts_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Capture datapath: clear on arm, record first edge per channel while armed.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
            ts_hit   <= '0;
            ts_q     <= '0;
            timeout  <= 1'b0;
        end else if (arm_go) begin
            word_cnt <= '0;
            ts_hit   <= '0;
            ts_q     <= '0;
            timeout  <= 1'b0;
        end else if (armed_ce) begin
            // Counter stops at the timeout word so it can never wrap.
            if (!last_word) word_cnt <= word_cnt + 1'b1;
            ts_hit <= hit_after;
            for (int c = 0; c < NUM_CH; c++) begin
                if (new_hit[c]) ts_q[c] <= {word_cnt, edge_idx[c]};
            end
            if (!all_hit && last_word) timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cmp_edge_stamp.sv
// Self-checking bench for cmp_edge_stamp: directed scenarios plus randomized
// captures checked against a sample-stream reference model.
module tb_cmp_edge_stamp;
    localparam int NCH = 2;
    localparam int WW  = 8;
    localparam int CW  = 8;
    localparam int TO  = 16;
    localparam int TSW = CW + 3;

    logic                adc_clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                ce = 1'b0;
    logic                arm = 1'b0;
    logic                ts_ready = 1'b0;
    logic [NCH*WW-1:0]   data_in = '0;
    logic                busy;
    logic                ts_valid;
    logic [NCH*TSW-1:0]  ts_data;
    logic [NCH-1:0]      ts_hit;
    logic                timeout;
`ifdef CMP_EDGE_POL_EN
    logic [NCH-1:0]      edge_pol = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: the sample stream per channel
    bit last_s [NCH];
    bit hist   [NCH][$];
    bit m_rec = 1'b0;

    cmp_edge_stamp #(.NUM_CH(NCH), .WORD_W(WW), .CNT_W(CW), .TIMEOUT_WORDS(TO)) dut (
`ifdef CMP_EDGE_POL_EN
        .edge_pol (edge_pol),
`endif
        .adc_clk  (adc_clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .data_in  (data_in),
        .arm      (arm),
        .busy     (busy),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .ts_data  (ts_data),
        .ts_hit   (ts_hit),
        .timeout  (timeout)
    );

    always #5 adc_clk = ~adc_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // one clock with the given inputs; outputs are stable on return
    task automatic cyc(input bit c, input logic [7:0] d0, input logic [7:0] d1, input bit a);
        logic [7:0] d [NCH];
        d[0] = d0;
        d[1] = d1;
        @(negedge adc_clk);
        ce = c;
        data_in = {d1, d0};
        arm = a;
        @(posedge adc_clk);
        if (c) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (m_rec) for (int b = 0; b < WW; b++) hist[ch].push_back(d[ch][b]);
                last_s[ch] = d[ch][WW-1];
            end
        end
        #1;
        ce = 1'b0;
        arm = 1'b0;
    endtask

    task automatic model_start();
        for (int ch = 0; ch < NCH; ch++) begin
            hist[ch].delete();
            hist[ch].push_back(last_s[ch]);
        end
        m_rec = 1'b1;
    endtask

    // first 0->1 transition in each channel's sample stream since arm
    task automatic model_eval(output bit done, output bit to, output logic [NCH-1:0] hit,
                              output logic [NCH*TSW-1:0] ts);
        int words;
        bit found;
        words = (hist[0].size() - 1) / WW;
        hit = '0;
        ts = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            found = 1'b0;
            for (int n = 1; n < hist[ch].size(); n++) begin
                if (!found && hist[ch][n] && !hist[ch][n-1]) begin
                    found = 1'b1;
                    hit[ch] = 1'b1;
                    ts[ch*TSW +: TSW] = TSW'(n - 1);
                end
            end
        end
        done = (&hit) || (words == TO);
        to = done && !(&hit);
    endtask

    task automatic pulse_reset();
        @(negedge adc_clk);
        #2 reset_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge adc_clk);
        reset_n = 1'b1;
        for (int ch = 0; ch < NCH; ch++) last_s[ch] = 1'b0;
        m_rec = 1'b0;
    endtask

    task automatic handshake();
        ts_ready = 1'b1;
        cyc(0, 8'h00, 8'h00, 0);
        ts_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || ts_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL handshake: busy=%b ts_valid=%b want 0 0", busy, ts_valid);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, ts_valid, timeout, ts_hit, ts_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_init: outs=%h want 0", {busy, ts_valid, timeout, ts_hit, ts_data});
        end
        release_reset();
        cyc(1, 8'h00, 8'h00, 0);
        cyc(0, 8'h00, 8'h00, 1);
        cyc(1, 8'h01, 8'h01, 0);
        n_cmp++;
        if (ts_valid !== 1'b1 || ts_hit !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_pre: ts_valid=%b ts_hit=%b want 1 11", ts_valid, ts_hit);
        end
        pulse_reset();
        n_cmp++;
        if ({busy, ts_valid, timeout, ts_hit, ts_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: outs=%h want 0", {busy, ts_valid, timeout, ts_hit, ts_data});
        end
        release_reset();
    endtask

    task automatic test_basic();
        cyc(1, 8'h00, 8'h00, 0);
        cyc(0, 8'h00, 8'h00, 1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy: busy=%b want 1", busy);
        end
        cyc(1, 8'h00, 8'h00, 0);
        cyc(1, 8'hF0, 8'h00, 0);
        n_cmp++;
        if (ts_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_early: ts_valid=%b want 0", ts_valid);
        end
        cyc(1, 8'h00, 8'h01, 0);
        n_cmp++;
        if ({ts_valid, timeout, ts_hit, ts_data} !== {1'b1, 1'b0, 2'b11, 11'd16, 11'd12}) begin
            n_bad++;
            $display("FAIL basic_result: valid=%b to=%b hit=%b data=%h want 1 0 11 %h",
                     ts_valid, timeout, ts_hit, ts_data, {11'd16, 11'd12});
        end
        handshake();
    endtask

    task automatic test_boundary();
        cyc(1, 8'h00, 8'h80, 0);
        cyc(0, 8'h00, 8'h00, 1);
        cyc(1, 8'h01, 8'h01, 0);
        n_cmp++;
        if (ts_valid !== 1'b0 || ts_hit !== 2'b01) begin
            n_bad++;
            $display("FAIL boundary_mid: ts_valid=%b ts_hit=%b want 0 01", ts_valid, ts_hit);
        end
        cyc(1, 8'h00, 8'h02, 0);
        n_cmp++;
        if ({ts_valid, timeout, ts_hit, ts_data} !== {1'b1, 1'b0, 2'b11, 11'd9, 11'd0}) begin
            n_bad++;
            $display("FAIL boundary_result: valid=%b to=%b hit=%b data=%h want 1 0 11 %h",
                     ts_valid, timeout, ts_hit, ts_data, {11'd9, 11'd0});
        end
        handshake();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        cyc(0, 8'h00, 8'h00, 1);
        for (int k = 0; k < TO; k++) begin
            if (k != 0) begin
                cyc(0, 8'hFF, 8'h0F, 0);
                if (ts_valid !== 1'b0) early++;
            end
            cyc(1, 8'h00, 8'h00, 0);
            if (k < TO - 1 && ts_valid !== 1'b0) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL timeout_early: ts_valid high on %0d cycles want 0", early);
        end
        n_cmp++;
        if ({ts_valid, timeout, ts_hit, ts_data} !== {1'b1, 1'b1, 2'b00, 22'd0}) begin
            n_bad++;
            $display("FAIL timeout_result: valid=%b to=%b hit=%b data=%h want 1 1 00 0",
                     ts_valid, timeout, ts_hit, ts_data);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        cyc(0, 8'h00, 8'h00, 1);
        cyc(1, 8'h00, 8'h00, 0);
        cyc(1, 8'h08, 8'h20, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 8'($urandom), 8'($urandom), 1);
            if ({busy, ts_valid, timeout, ts_hit, ts_data} !==
                {1'b1, 1'b1, 1'b0, 2'b11, 11'd13, 11'd11}) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL backpressure_hold: %0d cycles changed, data=%h want %h",
                     bad, ts_data, {11'd13, 11'd11});
        end
        ts_ready = 1'b1;
        cyc(1, 8'h01, 8'h01, 1);
        ts_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || ts_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_release: busy=%b ts_valid=%b want 0 0", busy, ts_valid);
        end
        cyc(1, 8'h00, 8'h00, 0);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_norestart: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_armed();
        cyc(0, 8'h00, 8'h00, 1);
        cyc(1, 8'h10, 8'h00, 0);
        n_cmp++;
        if (busy !== 1'b1 || ts_hit !== 2'b01) begin
            n_bad++;
            $display("FAIL rstarmed_pre: busy=%b ts_hit=%b want 1 01", busy, ts_hit);
        end
        pulse_reset();
        n_cmp++;
        if ({busy, ts_valid, ts_hit} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rstarmed_async: busy=%b valid=%b hit=%b want 0 0 00", busy, ts_valid, ts_hit);
        end
        release_reset();
        cyc(0, 8'h00, 8'h00, 1);
        cyc(1, 8'h04, 8'h00, 0);
        cyc(1, 8'h00, 8'h01, 0);
        n_cmp++;
        if ({ts_valid, timeout, ts_hit, ts_data} !== {1'b1, 1'b0, 2'b11, 11'd8, 11'd2}) begin
            n_bad++;
            $display("FAIL rstarmed_rearm: valid=%b to=%b hit=%b data=%h want 1 0 11 %h",
                     ts_valid, timeout, ts_hit, ts_data, {11'd8, 11'd2});
        end
        handshake();
    endtask

    task automatic test_random();
        bit done, to;
        logic [NCH-1:0] e_hit;
        logic [NCH*TSW-1:0] e_ts;
        logic [7:0] w0, w1;
        for (int it = 0; it < 40; it++) begin
            for (int k = $urandom_range(0, 3); k > 0; k--) cyc(1, 8'($urandom), 8'($urandom), 0);
            cyc($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 1);
            model_start();
            done = 1'b0;
            for (int cy = 0; cy < 200 && !done; cy++) begin
                w0 = ($urandom_range(0, 5) == 0) ? 8'($urandom) : (($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00);
                w1 = ($urandom_range(0, 5) == 0) ? 8'($urandom) : (($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00);
                cyc($urandom_range(0, 3) != 0, w0, w1, $urandom_range(0, 4) == 0);
                model_eval(done, to, e_hit, e_ts);
                n_cmp++;
                if (ts_valid !== done) begin
                    n_bad++;
                    $display("FAIL rand_valid it%0d cy%0d: ts_valid=%b want %b", it, cy, ts_valid, done);
                end
            end
            m_rec = 1'b0;
            n_cmp++;
            if (!done) begin
                n_bad++;
                $display("FAIL rand_bound it%0d: model never completed", it);
            end else if ({timeout, ts_hit, ts_data} !== {to, e_hit, e_ts}) begin
                n_bad++;
                $display("FAIL rand_result it%0d: to=%b hit=%b data=%h want %b %b %h",
                         it, timeout, ts_hit, ts_data, to, e_hit, e_ts);
            end
            handshake();
            if (busy !== 1'b0) begin
                pulse_reset();
                release_reset();
            end
        end
    endtask

    initial begin
        for (int ch = 0; ch < NCH; ch++) last_s[ch] = 1'b0;
        repeat (2) @(posedge adc_clk);
        #1;
        test_reset();
        test_basic();
        test_boundary();
        test_timeout();
        test_backpressure();
        test_reset_armed();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmp_edge_stamp.md
Name: cmp_edge_stamp

Overview:
Multi-channel comparator edge timestamper for the ETS front end.
- Operates on the adc_clk domain. Consumes the per-channel parallel words produced by the comparator deserialisers: WORD_W samples per adc_clk, bit 0 is the earliest sample.
- After an arm pulse, it records per channel the fine-resolution sample index of the first comparator rising edge.
- Results are returned through a valid/ready handshake, with a timeout if any channel never fires.

Parameters:
NUM_CH, 2, number of comparator channels.
WORD_W, 8, samples per word; power of 2, 2..16.
CNT_W, 10, word-counter width.
TIMEOUT_WORDS, 1023, armed words counted before forced completion; must be ≤ 2^CNT_W.
TS_W (localparam), CNT_W + clog2(WORD_W), per-channel timestamp width.

Ports:
adc_clk  in  1  sole clock; all logic on its rising edge.
reset_n  in  1  asynchronous active-low reset.
ce  in  1  data_in holds a valid word this cycle.
data_in  in  NUM_CH*WORD_W  channel c occupies [c*WORD_W +: WORD_W]; bit 0 is the earliest sample.
arm  in  1  start-capture pulse; honoured only in IDLE.
busy  out  1  high in ARMED and DONE.
ts_valid  out  1  result available.
ts_ready  in  1  consumer accepts the result.
ts_data  out  NUM_CH*TS_W  per-channel timestamp; channel c occupies [c*TS_W +: TS_W].
ts_hit  out  NUM_CH  channel recorded an edge.
timeout  out  1  capture ended by timeout.

Behaviour:
- Reset (asynchronous): state = IDLE. busy, ts_valid, timeout, ts_hit, ts_data, word_cnt and every prev_bit are all 0.
- prev_bit[c]:
  - Updated to data_in bit WORD_W-1 of channel c on every ce cycle, in all states.
  - Provides edge continuity across word boundaries, including the last word seen before arm.
- Edge definition, within one ce word:
  - Extended vector e = {word, prev_bit}.
  - Rising edge at index i when e[i] = 0 and e[i+1] = 1.
  - If several edges occur in one word, the lowest i wins.
- States and transitions:
  - IDLE: arm = 1 → ARMED. word_cnt, ts_hit, ts_data and timeout are cleared on that edge.
  - ARMED, on each ce cycle, for each channel with ts_hit[c] = 0 and an edge at i:
    - ts_hit[c] ← 1.
    - ts_data[c] ← word_cnt*WORD_W + i.
    - Channels already hit ignore later edges.
    - word_cnt increments.
  - ARMED completion:
    - If, after this word's update, all NUM_CH channels are hit → DONE, timeout = 0.
    - Otherwise, if word_cnt == TIMEOUT_WORDS-1 on this ce cycle → DONE, timeout = 1.
    - If all channels hit on the final word, the result is hit completion (timeout = 0).
    - Cycles with ce = 0 neither count nor detect edges.
  - DONE:
    - ts_valid = 1.
    - ts_data, ts_hit and timeout are held stable.
    - ts_valid & ts_ready → IDLE next cycle; ts_valid drops that cycle.
    - arm is ignored.
- Latency: the ce cycle carrying the completing word is followed by ts_valid = 1 at the next adc_clk edge (1 cycle).
- Unhit channels report ts_data = 0, ts_hit = 0.
- word_cnt never wraps: the timeout fires at or before its maximum value.
- arm in ARMED or DONE is ignored and does not restart the capture.
- reset_n low mid-capture: immediate return to IDLE with the reset values above; any pending result is discarded.

Optional Feature:
CMP_EDGE_POL_EN
- Defined: adds input edge_pol[NUM_CH] (0 = rising, 1 = falling).
  - Channel c detects on its word inverted (prev_bit inverted too) when edge_pol[c] = 1.
  - edge_pol is sampled on the arm cycle and held for the capture.
- Undefined: port absent; all channels detect rising edges only.

Test Plan:
Common setup: NUM_CH = 2, WORD_W = 8, CNT_W = 8, TIMEOUT_WORDS = 16.
1. Reset: assert reset_n = 0 mid-stream → busy = ts_valid = timeout = 0, ts_hit = 00, ts_data = 0 immediately (asynchronous).
2. Basic capture:
   - Stimulus: idle word ch0 = ch1 = 0x00; arm; armed ce words ch0: 0x00, 0xF0; ch1: 0x00, 0x00, 0x01.
   - Response: ts_data ch0 = 12, ch1 = 16; ts_hit = 11; timeout = 0; ts_valid high the cycle after the third word.
3. Word-boundary continuity:
   - Stimulus: pre-arm words ch0 = 0x00, ch1 = 0x80; armed words ch0: 0x01; ch1: 0x01, 0x02.
   - Response: ch0 = 0 (bit-0 edge from prev = 0); ch1 = 9 (no bit-0 edge because prev = 1; 0x02 bit 1 edge).
4. Timeout and gaps:
   - Stimulus: arm; 16 ce words of 0x00 interleaved with ce = 0 cycles.
   - Response: ts_valid after the 16th ce word only; timeout = 1, ts_hit = 00, ts_data = 0.
5. Backpressure and arm while busy:
   - Stimulus: completed capture; ts_ready = 0 for 5 cycles with arm pulses and new edges.
   - Response: ts_valid held and outputs unchanged; on ts_ready = 1, busy = 0 the next cycle; no new capture started.
6. Reset mid-ARMED:
   - Stimulus: ch0 hit recorded, then reset_n pulse.
   - Response: IDLE, ts_hit = 00. A new arm with ch0 0x04 gives ch0 = 2.
